// File: rtl/mario_gfx_pkg.sv
// Shared graphics types for the Mario sprite path: palette indices, 12-bit RGB
// and the sprite ROM geometry.
package mario_gfx_pkg;

    localparam int unsigned SPRITE_DIM = 16;

    typedef enum logic [1:0] {
        PAL_ALPHA = 2'b00,
        PAL_RED   = 2'b01,
        PAL_DKBRN = 2'b10,
        PAL_LTBRN = 2'b11
    } pal_idx_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t RGB_NONE  = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb12_t RGB_RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb12_t RGB_DKBRN = '{r: 4'h6, g: 4'h3, b: 4'h0};
    localparam rgb12_t RGB_LTBRN = '{r: 4'hF, g: 4'hB, b: 4'h7};

endpackage

// File: rtl/mario_palette_lut.sv
// Combinational palette lookup: sprite palette index to 12-bit RGB.
// Transparent maps to black; the caller masks it with the hit flag anyway.
module mario_palette_lut
    import mario_gfx_pkg::*;
(
    input  pal_idx_t pal,
    output rgb12_t   rgb
);

    always_comb begin
        rgb = RGB_NONE;
        case (pal)
            PAL_RED:   rgb = RGB_RED;
            PAL_DKBRN: rgb = RGB_DKBRN;
            PAL_LTBRN: rgb = RGB_LTBRN;
            default:   rgb = RGB_NONE;
        endcase
    end

endmodule

// File: rtl/mario_sprite_renderer.sv
// Two-stage pixel pipeline: beam position -> sprite ROM address (stage 1),
// returned palette index -> RGB and hit flag (stage 2).
module mario_sprite_renderer
    import mario_gfx_pkg::*;
#(
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned COORD_W    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] mario_x,
    input  logic [COORD_W-1:0] mario_y,
    input  logic               facing_left,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic               pix_valid_in,
    output logic [3:0]         rom_x,
    output logic [3:0]         rom_y,
    input  logic [1:0]         rom_pal,
    output logic               pix_valid_out,
    output logic               sprite_hit,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue
);

    localparam int unsigned BOX = SPRITE_DIM << SCALE_LOG2;

    logic [COORD_W-1:0] shadow_x_q, shadow_x_d;
    logic [COORD_W-1:0] shadow_y_q, shadow_y_d;
    logic               facing_q, facing_d;
    logic               armed_q, armed_d;

    logic [3:0] rom_x_q, rom_x_d;
    logic [3:0] rom_y_q, rom_y_d;
    logic       inbox_q, inbox_d;
    logic       valid1_q, valid1_d;

    logic       hit_q, hit_d;
    rgb12_t     rgb_q, rgb_d;
    logic       valid2_q, valid2_d;

    logic [COORD_W:0] dx, dy;
    logic             in_x, in_y;
    logic [3:0]       cx;
    rgb12_t           lut_rgb;

    mario_palette_lut u_lut (
        .pal (pal_idx_t'(rom_pal)),
        .rgb (lut_rgb)
    );

    always_comb begin
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        facing_d   = facing_q;
        armed_d    = armed_q;
        if (frame_start) begin
            shadow_x_d = mario_x;
            shadow_y_d = mario_y;
            facing_d   = facing_left;
            armed_d    = 1'b1;
        end

        // One extra bit keeps the difference signed: a beam left of/above the sprite
        // sets the MSB instead of wrapping into the box.
        dx   = {1'b0, draw_x} - {1'b0, shadow_x_q};
        dy   = {1'b0, draw_y} - {1'b0, shadow_y_q};
        in_x = !dx[COORD_W] && (dx < (COORD_W+1)'(BOX));
        in_y = !dy[COORD_W] && (dy < (COORD_W+1)'(BOX));
        cx   = 4'(dx >> SCALE_LOG2);

        rom_x_d  = facing_q ? (4'd15 - cx) : cx;
        rom_y_d  = 4'(dy >> SCALE_LOG2);
        inbox_d  = pix_valid_in & armed_q & in_x & in_y;
        valid1_d = pix_valid_in;

        hit_d    = inbox_q & (rom_pal != 2'b00);
        rgb_d    = hit_d ? lut_rgb : RGB_NONE;
        valid2_d = valid1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            facing_q   <= 1'b0;
            armed_q    <= 1'b0;
            rom_x_q    <= '0;
            rom_y_q    <= '0;
            inbox_q    <= 1'b0;
            valid1_q   <= 1'b0;
            hit_q      <= 1'b0;
            rgb_q      <= RGB_NONE;
            valid2_q   <= 1'b0;
        end else begin
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            facing_q   <= facing_d;
            armed_q    <= armed_d;
            rom_x_q    <= rom_x_d;
            rom_y_q    <= rom_y_d;
            inbox_q    <= inbox_d;
            valid1_q   <= valid1_d;
            hit_q      <= hit_d;
            rgb_q      <= rgb_d;
            valid2_q   <= valid2_d;
        end
    end

    assign rom_x         = rom_x_q;
    assign rom_y         = rom_y_q;
    assign pix_valid_out = valid2_q;
    assign sprite_hit    = hit_q;
    assign red           = rgb_q.r;
    assign green         = rgb_q.g;
    assign blue          = rgb_q.b;

endmodule

// File: tb/tb_mario_sprite_renderer.sv
// Bench for mario_sprite_renderer: directed screen scenarios plus randomized beam
// and position traffic, checked against a behavioural sprite-box model.
module tb_mario_sprite_renderer;

    localparam int SCALE = 2;
    localparam int BOXW  = 32;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic [9:0] mario_x, mario_y, draw_x, draw_y;
    logic       facing_left, pix_valid_in;
    logic [3:0] rom_x, rom_y;
    logic [1:0] rom_pal;
    logic       pix_valid_out, sprite_hit;
    logic [3:0] red, green, blue;

    logic [1:0] rom_mem [16][16];

    typedef struct {
        bit inbox;
        int rx;
        int ry;
        bit v;
        bit hit;
        int rgb;
    } ent_t;

    ent_t s1, s2;
    int   m_sx, m_sy;
    bit   m_face, m_armed;
    int   n_vec, n_err, hits;

    mario_sprite_renderer #(.SCALE_LOG2(1), .COORD_W(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .mario_x       (mario_x),
        .mario_y       (mario_y),
        .facing_left   (facing_left),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .pix_valid_in  (pix_valid_in),
        .rom_x         (rom_x),
        .rom_y         (rom_y),
        .rom_pal       (rom_pal),
        .pix_valid_out (pix_valid_out),
        .sprite_hit    (sprite_hit),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb rom_pal = rom_mem[rom_y][rom_x];

    function automatic int pal_rgb(input int p);
        case (p)
            1: return 'hF00;
            2: return 'h630;
            3: return 'hFB7;
            default: return 0;
        endcase
    endfunction

    function automatic int clampi(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int p);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                rom_mem[i][j] = 2'(p);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                rom_mem[i][j] = 2'($urandom_range(0, 3));
    endtask

    // Drive one beam pixel, predict it, advance one clock, then compare outputs.
    task automatic step(input bit fs, input int x, input int y, input bit v);
        ent_t e;
        int dx, dy, col, row;
        frame_start  = fs;
        draw_x       = 10'(x);
        draw_y       = 10'(y);
        pix_valid_in = v;
        dx = x - m_sx;
        dy = y - m_sy;
        e = '{default: 0};
        e.v = v;
        e.inbox = v && m_armed && dx >= 0 && dx < BOXW && dy >= 0 && dy < BOXW;
        if (e.inbox) begin
            col   = dx / SCALE;
            row   = dy / SCALE;
            e.rx  = m_face ? 15 - col : col;
            e.ry  = row;
            e.hit = (rom_mem[row][e.rx] != 2'b00);
            e.rgb = e.hit ? pal_rgb(int'(rom_mem[row][e.rx])) : 0;
        end
        if (fs) begin
            m_sx    = int'(mario_x);
            m_sy    = int'(mario_y);
            m_face  = facing_left;
            m_armed = 1'b1;
        end
        s2 = s1;
        s1 = e;
        @(negedge clk);
        chk("pix_valid_out", int'(pix_valid_out), int'(s2.v));
        chk("sprite_hit", int'(sprite_hit), int'(s2.hit));
        chk("rgb", int'({red, green, blue}), s2.rgb);
        if (s1.inbox) begin
            chk("rom_x", int'(rom_x), s1.rx);
            chk("rom_y", int'(rom_y), s1.ry);
        end
        if (sprite_hit) hits++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic sweep_row(input int y);
        for (int x = 0; x < 800; x++) step(1'b0, x, y, (x < 640) && (y < 480));
    endtask

    task automatic set_mario(input int x, input int y, input bit f);
        mario_x     = 10'(x);
        mario_y     = 10'(y);
        facing_left = f;
    endtask

    initial begin
        int h0;
        int rows [6] = '{0, 50, 60, 81, 479, 500};
        n_vec = 0; n_err = 0; hits = 0;
        s1 = '{default: 0};
        s2 = '{default: 0};
        m_sx = 0; m_sy = 0; m_face = 0; m_armed = 0;
        rst_n = 1'b0;
        frame_start = 0; pix_valid_in = 0;
        draw_x = '0; draw_y = '0;
        set_mario(100, 50, 0);
        fill(1);

        repeat (2) @(negedge clk);
        chk("reset_rom_x", int'(rom_x), 0);
        chk("reset_rom_y", int'(rom_y), 0);
        chk("reset_hit", int'(sprite_hit), 0);
        chk("reset_valid", int'(pix_valid_out), 0);
        chk("reset_rgb", int'({red, green, blue}), 0);
        rst_n = 1'b1;

        // Not yet armed: no hit anywhere even though the ROM is fully opaque.
        h0 = hits;
        foreach (rows[i]) sweep_row(rows[i]);
        idle(2);
        chk("unarmed_hits", hits - h0, 0);

        // Box at (100,50), facing right.
        step(1'b1, 0, 0, 1'b0);
        step(1'b0, 100, 50, 1'b1);
        chk("lit_rom_x_100_50", int'(rom_x), 0);
        chk("lit_rom_y_100_50", int'(rom_y), 0);
        step(1'b0, 131, 81, 1'b1);
        chk("lit_rom_x_131_81", int'(rom_x), 15);
        chk("lit_rom_y_131_81", int'(rom_y), 15);
        chk("lit_hit_100_50", int'(sprite_hit), 1);
        step(1'b0, 132, 50, 1'b1);
        chk("lit_hit_131_81", int'(sprite_hit), 1);
        step(1'b0, 99, 50, 1'b1);
        chk("lit_hit_132_50", int'(sprite_hit), 0);
        idle(1);
        chk("lit_hit_99_50", int'(sprite_hit), 0);
        idle(1);

        // Mirrored.
        set_mario(100, 50, 1);
        step(1'b1, 0, 0, 1'b0);
        step(1'b0, 100, 60, 1'b1);
        chk("lit_mirror_rom_x", int'(rom_x), 15);
        chk("lit_mirror_rom_y", int'(rom_y), 5);
        idle(1);
        chk("lit_mirror_hit", int'(sprite_hit), 1);
        chk("lit_mirror_rgb", int'({red, green, blue}), 'hF00);

        // Palette entries.
        fill(0);
        step(1'b0, 100, 60, 1'b1); idle(1);
        chk("lit_alpha_hit", int'(sprite_hit), 0);
        chk("lit_alpha_rgb", int'({red, green, blue}), 0);
        fill(3);
        step(1'b0, 110, 70, 1'b1); idle(1);
        chk("lit_ltbrn_rgb", int'({red, green, blue}), 'hFB7);
        fill(2);
        step(1'b0, 120, 80, 1'b1); idle(1);
        chk("lit_dkbrn_rgb", int'({red, green, blue}), 'h630);
        fill(1);

        // Position change mid-frame is deferred to the next frame_start.
        set_mario(100, 50, 0);
        step(1'b1, 0, 0, 1'b0);
        set_mario(300, 50, 0);
        step(1'b0, 100, 50, 1'b1); idle(1);
        chk("lit_midframe_old_pos", int'(sprite_hit), 1);
        step(1'b1, 100, 50, 1'b1);
        step(1'b0, 100, 50, 1'b1);
        chk("lit_fs_coincident_old", int'(sprite_hit), 1);
        step(1'b0, 300, 50, 1'b1);
        chk("lit_after_fs_old_gone", int'(sprite_hit), 0);
        idle(1);
        chk("lit_after_fs_new_pos", int'(sprite_hit), 1);

        // Right-edge clip, no wrap to the left edge.
        set_mario(620, 50, 0);
        step(1'b1, 0, 0, 1'b0);
        h0 = hits;
        sweep_row(50);
        idle(2);
        chk("lit_edge_hits", hits - h0, 20);

        // Sprite at the origin.
        set_mario(0, 0, 0);
        step(1'b1, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        chk("lit_origin_rom_x", int'(rom_x), 0);
        idle(1);
        chk("lit_origin_hit", int'(sprite_hit), 1);

        // Reset mid-line.
        for (int x = 0; x < 6; x++) step(1'b0, x, 3, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_midrst_hit", int'(sprite_hit), 0);
        chk("lit_midrst_valid", int'(pix_valid_out), 0);
        chk("lit_midrst_rgb", int'({red, green, blue}), 0);
        chk("lit_midrst_rom_x", int'(rom_x), 0);
        s1 = '{default: 0};
        s2 = '{default: 0};
        m_sx = 0; m_sy = 0; m_face = 0; m_armed = 0;
        @(negedge clk);
        rst_n = 1'b1;
        h0 = hits;
        sweep_row(3);
        idle(2);
        chk("lit_postrst_hits", hits - h0, 0);
        step(1'b1, 0, 0, 1'b0);
        step(1'b0, 2, 2, 1'b1); idle(1);
        chk("lit_rearm_hit", int'(sprite_hit), 1);

        // Randomized traffic.
        idle(2);
        fill_rand();
        set_mario($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)));
        step(1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 20000; i++) begin
            int x, y;
            if ($urandom_range(0, 19) == 0)
                set_mario($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end else begin
                x = clampi(m_sx + $urandom_range(0, 40) - 4);
                y = clampi(m_sy + $urandom_range(0, 40) - 4);
            end
            step($urandom_range(0, 49) == 0, x, y, $urandom_range(0, 9) != 0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
